dds_freq_ctrl: RTL and testbench



---
 rtl/dds_freq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dds_freq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_freq_ctrl.sv
// dds_freq_ctrl: debounced front-panel keys -> saturating 24-bit DDS frequency word with decade step and hold-to-repeat.
// Latency: K/k_valid update one edge after a press event or repeat tick; no backpressure, k_valid is a single-cycle pulse.
module dds_freq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int K_RESET         = 1000,
  parameter int K_MIN           = 1,
  parameter int K_MAX           = 166666
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_up_n,
  input  logic        key_down_n,
  input  logic        key_step_n,
  output logic [23:0] K,
  output logic [2:0]  step_idx,
  output logic        k_valid
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

  // key bit order: [0] up, [1] down, [2] step
  logic [2:0]    keys_n;
  logic [2:0]    sync1, sync2, deb, deb_d, armed;
  logic [1:0]    primed;
  logic [DW-1:0] cnt [3];
  logic [2:0]    press;

  assign keys_n = {key_step_n, key_down_n, key_up_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '1;
      sync2  <= '1;
      deb    <= '1;
      deb_d  <= '1;
      armed  <= '0;
      primed <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1  <= keys_n;
      sync2  <= sync1;
      deb_d  <= deb;
      primed <= {primed[0], 1'b1};
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DW'(1);
        end
        // A key must be seen released once the synchronizer holds real samples;
        // a key held through reset therefore cannot fire until released and re-pressed.
        if (primed[1] && sync2[i] && deb[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign press = deb_d & ~deb & armed;

  function automatic logic [24:0] step_of(input logic [2:0] idx);
    case (idx)
      3'd0:    step_of = 25'd1;
      3'd1:    step_of = 25'd10;
      3'd2:    step_of = 25'd100;
      3'd3:    step_of = 25'd1000;
      3'd4:    step_of = 25'd10000;
      3'd5:    step_of = 25'd100000;
      default: step_of = 25'd1;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          act, act_up, held_released;

  assign held_released = dir_q ? deb[0] : deb[1];

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    act     = 1'b0;
    act_up  = dir_q;
    case (state_q)
      ST_IDLE: begin
        // simultaneous up+down presses cancel each other
        if (press[0] ^ press[1]) begin
          act     = 1'b1;
          act_up  = press[0];
          dir_d   = press[0];
          timer_d = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (held_released) begin
          state_d = ST_IDLE;
        end else if (timer_q == TW'(REPEAT_DELAY - 1)) begin
          act     = 1'b1;
          timer_d = '0;
          state_d = ST_REPEAT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_REPEAT: begin
        if (held_released) begin
          state_d = ST_IDLE;
        end else if (timer_q == TW'(REPEAT_PERIOD - 1)) begin
          act     = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

  logic [24:0] k_ext, step_v, k_sum, k_up, k_dn, k_next;

  always_comb begin
    k_ext  = {1'b0, K};
    step_v = step_of(step_idx);
    k_sum  = k_ext + step_v;
    k_up   = (k_sum > 25'(K_MAX)) ? 25'(K_MAX) : k_sum;
    k_dn   = (k_ext < step_v + 25'(K_MIN)) ? 25'(K_MIN) : k_ext - step_v;
    k_next = act_up ? k_up : k_dn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      K        <= 24'(K_RESET);
      step_idx <= '0;
      k_valid  <= 1'b0;
    end else begin
      if (act) begin
        K       <= k_next[23:0];
        k_valid <= (k_next != k_ext);
      end else begin
        k_valid <= 1'b0;
      end
      // the action above already used the old step_idx
      if (press[2]) step_idx <= (step_idx == 3'd5) ? 3'd0 : step_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_dds_freq_ctrl.sv
// Directed bench for dds_freq_ctrl: expected K values queued at stimulus time, popped on each k_valid pulse.
module tb_dds_freq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_up_n, key_down_n, key_step_n;
  logic [23:0] K;
  logic [2:0]  step_idx;
  logic        k_valid;

  int total = 0;
  int bad   = 0;
  int kv_cnt = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  dds_freq_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .K_RESET        (1000),
    .K_MIN          (1),
    .K_MAX          (166666)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_up_n  (key_up_n),
    .key_down_n(key_down_n),
    .key_step_n(key_step_n),
    .K         (K),
    .step_idx  (step_idx),
    .k_valid   (k_valid)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && k_valid === 1'b1) begin
      kv_cnt++;
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL kv_unexpected observed K=%0d expected no k_valid", K);
      end
      if (exp_q.size() > 0) begin
        int e;
        e = exp_q.pop_front();
        chk("kv_K", int'(K), e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
  endtask

  task automatic set_key(input int which, input logic lvl);
    case (which)
      0: key_up_n   = lvl;
      1: key_down_n = lvl;
      default: key_step_n = lvl;
    endcase
  endtask

  task automatic tap(input int which, input int hold);
    set_key(which, 1'b0);
    cyc(hold);
    set_key(which, 1'b1);
    cyc(12);
  endtask

  initial begin
    int k0;
    rst_n = 1'b0;
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    key_step_n = 1'b1;
    cyc(3);
    chk("rst_K", int'(K), 1000);
    chk("rst_step", int'(step_idx), 0);
    chk("rst_kvalid", int'(k_valid), 0);
    rst_n = 1'b1;
    cyc(3);
    chk("idle_K", int'(K), 1000);

    // single up press
    k0 = kv_cnt;
    exp_q.push_back(1001);
    tap(0, 10);
    chk("up1_K", int'(K), 1001);
    chk("up1_pulses", kv_cnt - k0, 1);
    chk("up1_step", int'(step_idx), 0);

    // step to 1000, down clamps to K_MIN, further down does nothing
    do_reset();
    for (int i = 0; i < 3; i++) tap(2, 10);
    chk("step3", int'(step_idx), 3);
    k0 = kv_cnt;
    exp_q.push_back(1);
    tap(1, 10);
    chk("dn_clamp_K", int'(K), 1);
    chk("dn_clamp_pulses", kv_cnt - k0, 1);
    k0 = kv_cnt;
    tap(1, 10);
    chk("dn_limit_K", int'(K), 1);
    chk("dn_limit_pulses", kv_cnt - k0, 0);

    // step 5, saturate at K_MAX, wrap step index
    tap(2, 10);
    tap(2, 10);
    chk("step5", int'(step_idx), 5);
    k0 = kv_cnt;
    exp_q.push_back(100001);
    tap(0, 10);
    chk("up_big_K", int'(K), 100001);
    exp_q.push_back(166666);
    tap(0, 10);
    chk("up_sat_K", int'(K), 166666);
    tap(0, 10);
    chk("up_limit_K", int'(K), 166666);
    chk("sat_pulses", kv_cnt - k0, 2);
    tap(2, 10);
    chk("step_wrap", int'(step_idx), 0);

    // hold-to-repeat with a down press ignored mid-hold
    do_reset();
    chk("rep_rst_K", int'(K), 1000);
    k0 = kv_cnt;
    for (int i = 1; i <= 6; i++) exp_q.push_back(1000 + i);
    key_up_n = 1'b0;
    cyc(20);
    key_down_n = 1'b0;
    cyc(10);
    key_down_n = 1'b1;
    cyc(26);
    key_up_n = 1'b1;
    cyc(20);
    chk("rep_K", int'(K), 1006);
    chk("rep_pulses", kv_cnt - k0, 6);
    chk("rep_drain", exp_q.size(), 0);

    // simultaneous up/down, then a short glitch
    do_reset();
    k0 = kv_cnt;
    key_up_n = 1'b0;
    key_down_n = 1'b0;
    cyc(10);
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    cyc(12);
    chk("both_K", int'(K), 1000);
    chk("both_pulses", kv_cnt - k0, 0);
    tap(0, 3);
    chk("glitch_K", int'(K), 1000);
    chk("glitch_pulses", kv_cnt - k0, 0);
    exp_q.push_back(1001);
    tap(0, 10);
    chk("after_glitch_K", int'(K), 1001);

    // reset during REPEAT with the key held across reset release
    do_reset();
    exp_q.push_back(1001);
    exp_q.push_back(1002);
    key_up_n = 1'b0;
    cyc(32);
    chk("pre_rst_K", int'(K), 1002);
    chk("pre_rst_drain", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_K", int'(K), 1000);
    chk("async_rst_kvalid", int'(k_valid), 0);
    cyc(2);
    rst_n = 1'b1;
    k0 = kv_cnt;
    cyc(20);
    chk("held_K", int'(K), 1000);
    chk("held_pulses", kv_cnt - k0, 0);
    key_up_n = 1'b1;
    cyc(12);
    chk("released_K", int'(K), 1000);
    exp_q.push_back(1001);
    tap(0, 10);
    chk("repress_K", int'(K), 1001);
    chk("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
